// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the RSA key blocks.
package rsa_pkg;
  localparam int WIDTH     = 64;
  localparam int T_WIDTH   = 66;
  localparam int DIV_STEPS = 64;
  localparam int CNT_W     = $clog2(DIV_STEPS + 1);

  typedef enum logic [2:0] {IDLE, INIT, CHECK, DIVIDE, UPDATE, FIXUP, END} state_t;
endpackage

// File: rtl/rsa_divmod.sv
// Restoring divider: one quotient bit per cycle, MSB first, folding quotient*mul_operand
// into prod on the fly. The div_start edge already performs the first step.
module rsa_divmod
  import rsa_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      div_start,
  input  logic [WIDTH-1:0]          dividend,
  input  logic [WIDTH-1:0]          divisor,
  input  logic signed [T_WIDTH-1:0] mul_operand,
  output logic [WIDTH-1:0]          rem,
  output logic signed [T_WIDTH-1:0] prod,
  output logic                      busy,
  output logic                      div_done
);
  logic [WIDTH-1:0]          dvd_q, dsr_q;
  logic signed [T_WIDTH-1:0] mul_q;
  logic [CNT_W-1:0]          cnt;

  logic [WIDTH-1:0]          src_rem, src_dvd, src_dsr, nrem, ndvd;
  logic signed [T_WIDTH-1:0] src_prod, src_mul, nprod;
  logic [WIDTH:0]            trial;
  logic                      qbit;

  // On div_start the step works on the fresh operands instead of the registers.
  always_comb begin
    src_rem  = div_start ? '0          : rem;
    src_dvd  = div_start ? dividend    : dvd_q;
    src_dsr  = div_start ? divisor     : dsr_q;
    src_prod = div_start ? '0          : prod;
    src_mul  = div_start ? mul_operand : mul_q;
    trial    = {src_rem, src_dvd[WIDTH-1]};
    qbit     = trial >= {1'b0, src_dsr};
    nrem     = qbit ? WIDTH'(trial - {1'b0, src_dsr}) : trial[WIDTH-1:0];
    ndvd     = {src_dvd[WIDTH-2:0], 1'b0};
    nprod    = {src_prod[T_WIDTH-2:0], 1'b0} + (qbit ? src_mul : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0; prod <= '0; dvd_q <= '0; dsr_q <= '0; mul_q <= '0;
      cnt <= '0; busy <= 1'b0; div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start || busy) begin
        rem   <= nrem;
        prod  <= nprod;
        dvd_q <= ndvd;
        dsr_q <= src_dsr;
        mul_q <= src_mul;
      end
      if (div_start) begin
        cnt  <= CNT_W'(1);
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIV_STEPS - 1)) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/decryption_key.sv
// RSA private exponent d = e^-1 mod phi_n by sequential extended Euclid.
// Define DECRYPTION_KEY_ITER_COUNT_EN to expose the saturating iteration counter iter_count.
module decryption_key
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] phi_n,
  input  logic [WIDTH-1:0] e,
  input  logic             start_compute,
  output logic [WIDTH-1:0] d,
  output logic             error,
  output logic             done_compute
`ifdef DECRYPTION_KEY_ITER_COUNT_EN
  , output logic [6:0]     iter_count
`endif
);
  state_t                    state, state_nx;
  logic [WIDTH-1:0]          r0, r1, phi_q;
  logic signed [T_WIDTH-1:0] t0, t1;
  logic                      div_start, div_busy, div_done, illegal;
  logic [WIDTH-1:0]          div_rem;
  logic signed [T_WIDTH-1:0] div_prod;

  rsa_divmod u_div (
    .clk(clk), .reset(reset), .div_start(div_start),
    .dividend(r0), .divisor(r1), .mul_operand(t1),
    .rem(div_rem), .prod(div_prod), .busy(div_busy), .div_done(div_done)
  );

  assign illegal = (phi_q < WIDTH'(2)) || (r1 == '0) || (r1 >= phi_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_compute) state_nx = INIT;
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = illegal ? END : DIVIDE;
      DIVIDE:  if (div_done) state_nx = UPDATE;
      UPDATE:  state_nx = (div_rem == '0) ? FIXUP : DIVIDE;
      FIXUP:   state_nx = END;
      END:     if (!start_compute) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done_compute = (state == END);
    div_start    = (state == DIVIDE) && !div_busy && !div_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0 <= '0; r1 <= '0; phi_q <= '0; t0 <= '0; t1 <= '0;
      d <= '0; error <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          r0 <= phi_n; r1 <= e; phi_q <= phi_n;
          t0 <= '0; t1 <= T_WIDTH'(1);
          d <= '0; error <= 1'b0;
        end
        CHECK: if (illegal) error <= 1'b1;
        UPDATE: begin
          r0 <= r1; r1 <= div_rem;
          t0 <= t1; t1 <= t0 - div_prod;
        end
        FIXUP: begin
          // Low WIDTH bits of t0+phi_q equal the wrapped sum, so no wide add is needed.
          if (r0 != WIDTH'(1)) error <= 1'b1;
          else d <= t0[WIDTH-1:0] + (t0[T_WIDTH-1] ? phi_q : '0);
        end
        default: ;
      endcase
    end
  end

`ifdef DECRYPTION_KEY_ITER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || state == INIT)                 iter_count <= '0;
    else if (state == UPDATE && iter_count != 7'd127) iter_count <= iter_count + 7'd1;
  end
`endif
endmodule

// File: tb/tb_decryption_key.sv
// Directed + randomized bench for decryption_key against an arbitrary-precision Euclid model.
module tb_decryption_key;
  logic        clk = 1'b0;
  logic        reset, start_compute, error, done_compute;
  logic [63:0] phi_n, e, d;
`ifdef DECRYPTION_KEY_ITER_COUNT_EN
  logic [6:0]  iter_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_d;
  logic        exp_err;
  int          exp_iters, exp_lat;

  always #5 clk = ~clk;

  decryption_key dut (
    .clk(clk), .reset(reset), .phi_n(phi_n), .e(e), .start_compute(start_compute),
    .d(d), .error(error), .done_compute(done_compute)
`ifdef DECRYPTION_KEY_ITER_COUNT_EN
    , .iter_count(iter_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Unbounded-style extended Euclid on 132-bit signed values; also yields latency.
  task automatic ref_model(input logic [63:0] p, input logic [63:0] ee,
                           output logic [63:0] rd, output logic rerr,
                           output int iters, output int lat);
    logic signed [131:0] a, b, q, r, x0, x1, xt, pm;
    iters = 0; rd = '0; rerr = 1'b0; lat = 3;
    if (p < 2 || ee == 0 || ee >= p) begin
      rerr = 1'b1;
      return;
    end
    a = {68'd0, p}; b = {68'd0, ee}; pm = {68'd0, p};
    x0 = 0; x1 = 1;
    while (b != 0) begin
      q = a / b; r = a % b;
      a = b; b = r;
      xt = x0 - q * x1; x0 = x1; x1 = xt;
      iters++;
    end
    lat = 4 + 66 * iters;
    if (a != 1) rerr = 1'b1;
    else begin
      xt = x0 % pm;
      if (xt < 0) xt = xt + pm;
      rd = xt[63:0];
    end
  endtask

  // Raises start, waits for done with a bound, checks latency and results; start stays
  // high on return unless pulse dropped it after the first edge.
  task automatic run_case(input string tag, input logic [63:0] p, input logic [63:0] ee,
                          input bit pulse);
    int n;
    logic [127:0] prodm;
    ref_model(p, ee, exp_d, exp_err, exp_iters, exp_lat);
    phi_n = p; e = ee; start_compute = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (pulse && n == 1) start_compute = 1'b0;
      if (n == 2) begin phi_n = {$urandom, $urandom}; e = {$urandom, $urandom}; end
    end while (!done_compute && n < 7000);
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_d"}, 128'(d), 128'(exp_d));
    check({tag, "_error"}, 128'(error), 128'(exp_err));
    if (!exp_err) begin
      prodm = ({64'd0, d} * {64'd0, ee}) % {64'd0, p};
      check({tag, "_inverse"}, prodm, 128'd1);
    end
`ifdef DECRYPTION_KEY_ITER_COUNT_EN
    check({tag, "_iters"}, 128'(iter_count), 128'(exp_iters > 127 ? 127 : exp_iters));
`endif
    if (pulse) begin
      tick();
      check({tag, "_done_one_cycle"}, 128'(done_compute), 128'd0);
    end
  endtask

  task automatic finish_case(input string tag);
    start_compute = 1'b0;
    tick();
    check({tag, "_done_clear"}, 128'(done_compute), 128'd0);
    check({tag, "_d_hold"}, 128'(d), 128'(exp_d));
    check({tag, "_err_hold"}, 128'(error), 128'(exp_err));
  endtask

  initial begin
    logic [63:0] rp, re;
    reset = 1'b1; start_compute = 1'b0; phi_n = '0; e = '0;
    tick(); tick();
    check("rst_d", 128'(d), 128'd0);
    check("rst_error", 128'(error), 128'd0);
    check("rst_done", 128'(done_compute), 128'd0);
    reset = 1'b0;
    tick();

    run_case("3120_17", 64'd3120, 64'd17, 1'b0);
    check("3120_17_const", 128'(d), 128'd2753);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_done", 128'(done_compute), 128'd1);
      check("hold_d", 128'(d), 128'd2753);
    end
    finish_case("3120_17");

    // Reassert: INIT must clear d; then reset lands mid-divide.
    phi_n = 64'd3120; e = 64'd17; start_compute = 1'b1;
    tick(); tick();
    check("reinit_d_clear", 128'(d), 128'd0);
    repeat (20) tick();
    reset = 1'b1; start_compute = 1'b0;
    tick();
    check("midrst_d", 128'(d), 128'd0);
    check("midrst_error", 128'(error), 128'd0);
    check("midrst_done", 128'(done_compute), 128'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_idle", 128'(done_compute), 128'd0);

    run_case("rerun", 64'd3120, 64'd17, 1'b0);
    check("rerun_const", 128'(d), 128'd2753);
    finish_case("rerun");

    run_case("40_7", 64'd40, 64'd7, 1'b0);
    check("40_7_const", 128'(d), 128'd23);
    finish_case("40_7");
    run_case("40_1", 64'd40, 64'd1, 1'b0);
    check("40_1_const", 128'(d), 128'd1);
    finish_case("40_1");
    run_case("40_6", 64'd40, 64'd6, 1'b0);
    check("40_6_const_err", 128'(error), 128'd1);
    finish_case("40_6");
    run_case("40_0", 64'd40, 64'd0, 1'b0);
    finish_case("40_0");
    run_case("40_40", 64'd40, 64'd40, 1'b0);
    finish_case("40_40");
    run_case("1_0", 64'd1, 64'd0, 1'b0);
    finish_case("1_0");
    run_case("2_1", 64'd2, 64'd1, 1'b0);
    finish_case("2_1");
    run_case("pulse_40_7", 64'd40, 64'd7, 1'b1);
    tick();

    run_case("big", 64'hFFFF_FFFF_FFFF_FFC5, 64'd65537, 1'b0);
    finish_case("big");

    for (int i = 0; i < 6; i++) begin
      rp = {$urandom, $urandom};
      re = {$urandom, $urandom} % rp;
      if (i % 2 == 0) begin rp[0] = 1'b1; re[0] = 1'b1; end
      run_case("rand", rp, re, 1'b0);
      finish_case("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
